// File: rtl/stream_inst_sync_sink.sv
//==============================================================================
// Module   : stream_inst_sync_sink
// Brief    : Synchronises an asynchronous drive/free instruction stream into clk
//            and buffers the words in a first-word fall-through FIFO.
//            Optional macro STREAM_SYNC_3FF_EN adds a third synchroniser flop.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module stream_inst_sync_sink #(
   parameter int DATA_WIDTH        = 128,
   parameter int DEPTH             = 4,
   parameter int FREE_PULSE_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_drive,
   output logic                         o_free,
   input  logic [DATA_WIDTH-1:0]        i_data,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [DATA_WIDTH-1:0]        o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_overrun
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = $clog2(DEPTH + 1);
   localparam int c_fw = (FREE_PULSE_CYCLES > 1) ? $clog2(FREE_PULSE_CYCLES) : 1;

   localparam logic [c_cw-1:0] c_depth     = c_cw'(DEPTH);
   localparam logic [c_fw-1:0] c_free_load = c_fw'(FREE_PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_FREE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Drive-event synchroniser
   // ---------------------------------------------------------------------------
   logic w_sync_in;
   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic w_evt;

`ifdef STREAM_SYNC_3FF_EN
   logic r_s0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s0 <= 1'b0;
      end else begin
         r_s0 <= i_drive;
      end
   end

   assign w_sync_in = r_s0;
`else
   assign w_sync_in = i_drive;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= w_sync_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_evt = r_s2 & ~r_s3;

   // ---------------------------------------------------------------------------
   // FIFO status and handshake
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]       r_wr_ptr;
   logic [c_aw-1:0]       r_rd_ptr;
   logic [c_cw-1:0]       r_count;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_wr;
   logic                  w_space;

   state_t                r_state;
   logic [c_fw-1:0]       r_free_cnt;
   logic                  r_free;
   logic                  r_overrun;

   assign w_full  = (r_count == c_depth);
   assign o_valid = (r_count != '0);
   assign w_pop   = o_valid & i_ready;
   // A pop on the same edge frees a slot for a word waiting in PEND.
   assign w_space = ~w_full | w_pop;
   assign w_wr    = ((r_state == ST_IDLE) & w_evt & ~w_full) |
                    ((r_state == ST_PEND) & w_space);

   // ---------------------------------------------------------------------------
   // Capture FSM with registered free pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_free     <= 1'b0;
         r_free_cnt <= '0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_evt && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_evt) begin
                  if (w_wr) begin
                     r_state    <= ST_FREE;
                     r_free     <= 1'b1;
                     r_free_cnt <= c_free_load;
                  end else begin
                     r_state <= ST_PEND;
                  end
               end
            end
            ST_PEND: begin
               if (w_wr) begin
                  r_state    <= ST_FREE;
                  r_free     <= 1'b1;
                  r_free_cnt <= c_free_load;
               end
            end
            ST_FREE: begin
               if (r_free_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_free  <= 1'b0;
               end else begin
                  r_free_cnt <= r_free_cnt - c_fw'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_free  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO storage, pointers and occupancy
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count   = r_count;
   assign o_full    = w_full;
   assign o_free    = r_free;
   assign o_overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_stream_inst_sync_sink.sv
//==============================================================================
// Module   : tb_stream_inst_sync_sink
// Brief    : Scoreboard bench for stream_inst_sync_sink (directed vectors).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stream_inst_sync_sink;

   localparam int c_dw    = 128;
   localparam int c_depth = 4;
`ifdef STREAM_SYNC_3FF_EN
   localparam int c_lat = 3;
`else
   localparam int c_lat = 2;
`endif

   logic              clk;
   logic              rst;
   logic              i_drive;
   logic              o_free;
   logic [c_dw-1:0]   i_data;
   logic              o_valid;
   logic              i_ready;
   logic [c_dw-1:0]   o_data;
   logic [2:0]        o_count;
   logic              o_full;
   logic              o_overrun;

   int                checks   = 0;
   int                failures = 0;
   logic [c_dw-1:0]   r_sb_q[$];

   stream_inst_sync_sink #(
      .DATA_WIDTH       (c_dw),
      .DEPTH            (c_depth),
      .FREE_PULSE_CYCLES(2)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_drive   (i_drive),
      .o_free    (o_free),
      .i_data    (i_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_data    (o_data),
      .o_count   (o_count),
      .o_full    (o_full),
      .o_overrun (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_free(input logic level, input string name);
      int n;
      n = 0;
      while (o_free !== level && n < 40) begin
         step();
         n++;
      end
      if (o_free !== level) fail_timeout(name);
   endtask

   // Full four-phase handshake of one word with the sink.
   task automatic send_word(input logic [c_dw-1:0] d);
      r_sb_q.push_back(d);
      i_data  = d;
      i_drive = 1'b1;
      wait_free(1'b1, "send_free_hi");
      i_drive = 1'b0;
      wait_free(1'b0, "send_free_lo");
      repeat (3) step();
   endtask

   // Monitor: compares every accepted head word against the scoreboard.
   always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
         if (r_sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_pop: got %0h expected no word", o_data);
         end else begin
            logic [c_dw-1:0] exp;
            exp = r_sb_q.pop_front();
            checks++;
            if (o_data !== exp) begin
               failures++;
               $display("FAIL sb_data: got %0h expected %0h at %0t", o_data, exp, $time);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      int   n;
      rst     = 1'b1;
      i_drive = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      repeat (3) step();
      chk("rst_free",    c_dw'(o_free),    '0);
      chk("rst_valid",   c_dw'(o_valid),   '0);
      chk("rst_data",    o_data,           '0);
      chk("rst_count",   c_dw'(o_count),   '0);
      chk("rst_full",    c_dw'(o_full),    '0);
      chk("rst_overrun", c_dw'(o_overrun), '0);
      rst = 1'b0;
      repeat (2) step();

      // Single word: exact latency and pulse width.
      r_sb_q.push_back(c_dw'(128'hA5));
      i_data  = c_dw'(128'hA5);
      i_drive = 1'b1;
      for (int k = 0; k <= c_lat + 2; k++) begin
         step();
         chk($sformatf("single_valid_E%0d", k), c_dw'(o_valid), c_dw'(k >= c_lat));
         chk($sformatf("single_free_E%0d", k), c_dw'(o_free), c_dw'((k == c_lat) || (k == c_lat + 1)));
         if (k == c_lat) begin
            chk("single_data",  o_data,         c_dw'(128'hA5));
            chk("single_count", c_dw'(o_count), c_dw'(1));
         end
      end
      i_drive = 1'b0;
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      chk("single_drained", c_dw'(o_count), '0);
      repeat (3) step();

      // Fill to full, then a fifth word must wait in PEND.
      for (int w = 1; w <= 4; w++) send_word(c_dw'(w));
      chk("fill_full",  c_dw'(o_full),  c_dw'(1));
      chk("fill_count", c_dw'(o_count), c_dw'(4));
      r_sb_q.push_back(c_dw'(5));
      i_data  = c_dw'(5);
      i_drive = 1'b1;
      seen    = 1'b0;
      repeat (10) begin
         step();
         if (o_free) seen = 1'b1;
      end
      chk("pend_no_free", c_dw'(seen),    '0);
      chk("pend_count",   c_dw'(o_count), c_dw'(4));
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      chk("pend_pop_write_count", c_dw'(o_count), c_dw'(4));
      chk("pend_free",            c_dw'(o_free),  c_dw'(1));
      i_drive = 1'b0;
      wait_free(1'b0, "pend_free_lo");
      repeat (3) step();

      // Drain in order.
      i_ready = 1'b1;
      n = 0;
      while (o_count != 0 && n < 20) begin
         step();
         n++;
      end
      if (o_count != 0) fail_timeout("drain");
      chk("drain_valid", c_dw'(o_valid), '0);
      chk("drain_data",  o_data,         '0);
      chk("drain_sb",    c_dw'(r_sb_q.size()), '0);
      step();
      chk("pop_empty_count", c_dw'(o_count), '0);
      i_ready = 1'b0;

      // Overrun: a second rising edge of drive lands while free is active.
      r_sb_q.push_back(c_dw'(128'h77));
      i_data  = c_dw'(128'h77);
      i_drive = 1'b1;
      step();
      i_drive = 1'b0;
      step();
      i_drive = 1'b1;
      wait_free(1'b1, "ovr_free_hi");
      wait_free(1'b0, "ovr_free_lo");
      seen = 1'b0;
      repeat (8) begin
         step();
         if (o_free) seen = 1'b1;
      end
      chk("ovr_flag",     c_dw'(o_overrun), c_dw'(1));
      chk("ovr_count",    c_dw'(o_count),   c_dw'(1));
      chk("ovr_no_extra", c_dw'(seen),      '0);
      i_drive = 1'b0;
      repeat (4) step();
      chk("ovr_sticky", c_dw'(o_overrun), c_dw'(1));

      // Reset in the first free cycle with two words stored.
      r_sb_q.push_back(c_dw'(128'h88));
      i_data  = c_dw'(128'h88);
      i_drive = 1'b1;
      wait_free(1'b1, "rst_mid_free_hi");
      chk("rst_mid_pre_count", c_dw'(o_count), c_dw'(2));
      rst     = 1'b1;
      i_drive = 1'b0;
      step();
      chk("rst_mid_free",    c_dw'(o_free),    '0);
      chk("rst_mid_valid",   c_dw'(o_valid),   '0);
      chk("rst_mid_count",   c_dw'(o_count),   '0);
      chk("rst_mid_overrun", c_dw'(o_overrun), '0);
      r_sb_q.delete();
      rst = 1'b0;
      repeat (3) step();

      // Normal operation resumes after the mid-pulse reset.
      send_word(c_dw'(128'hDEAD_BEEF));
      chk("post_rst_count", c_dw'(o_count), c_dw'(1));
      i_ready = 1'b1;
      step();
      i_ready = 1'b0;
      chk("post_rst_sb", c_dw'(r_sb_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
